march_scheduler: RTL and testbench
==================================

// Module: march_scheduler
// PURPOSE
//  Sequences one frame of ray marching across NUM_CORES parallel marcher cores.
//  Walks pixel coords raster order, issues each pixel to an idle core, and round-robin arbitrates finished results onto the single framebuffer write port.
//  Pulses new_frame_out (drives bram_manager swap_buffers) once every pixel of the frame is written.
//  Sits between user_control/ray cores and bram_manager; replaces single-core ray_marcher sequencing.
// PARAMETERS
//  NUM_CORES   4    parallel marcher cores (1..8)
//  WIDTH       `DISPLAY_WIDTH   pixels per line
//  HEIGHT      `DISPLAY_HEIGHT  lines per frame
// PORTS
//  clk_in           in   1             system clock (sys_clk); single clock domain
//  rst_in           in   1             async active-high reset
//  pause_in         in   1             1 = stop issuing new pixels; in-flight results still drain
//  core_start_out   out  NUM_CORES     one-hot 1-cycle issue pulse to core i
//  hcount_out       out  `H_BITS       pixel x accompanying core_start_out
//  vcount_out       out  `V_BITS       pixel y accompanying core_start_out
//  core_done_in     in   NUM_CORES     core i result ready; held high until acked
//  core_color_in    in   4*NUM_CORES   core i colour in bits [4i+3:4i]
//  core_ack_out     out  NUM_CORES     one-hot 1-cycle ack; result consumed this cycle
//  write_enable_out out  1             framebuffer write strobe
//  write_addr_out   out  `ADDR_BITS    vcount*WIDTH+hcount of the pixel written
//  write_data_out   out  4             colour written
//  new_frame_out    out  1             1-cycle swap pulse
// BEHAVIOUR
//  Reset: state=ISSUE, pixel ptr=(0,0), all cores idle, rr ptr=0; every output 0.
//  Per-core tag reg holds address of pixel issued; busy bit set on issue, cleared on ack.
//  ISSUE: if !pause_in and any core idle, pulse core_start_out of lowest-index idle core with current (h,v), store tag, advance ptr; max one issue/cycle.
//   ptr advance: h==WIDTH-1 -> h=0,v++; at (WIDTH-1,HEIGHT-1) issue then go DRAIN.
//  Write arbiter (all states): among busy cores with core_done_in, grant first at/after rr ptr;
//   same cycle assert core_ack_out[g], write_enable_out=1, addr=tag[g], data=color[g] (combinational outputs); rr ptr <- g+1 mod NUM_CORES.
//   Max one write/cycle. core_done_in from a non-busy core is ignored.
//  Core acked in cycle t is idle for issue from cycle t+1, not t.
//  DRAIN: no issues; when no core busy -> SWAP.
//  SWAP: new_frame_out=1 for one cycle, ptr=(0,0), -> ISSUE. Issue resumes next cycle.
//  pause_in in DRAIN/SWAP: no effect. Deasserting pause resumes at held ptr; no pixel skipped or duplicated.
//  Reset mid-frame: all state discarded immediately (async); cores reset by same rst_in, so no stale done.
//  Latency: issue-to-write bounded only by core; frame = exactly WIDTH*HEIGHT writes then one swap pulse.
//  addr arithmetic: tag computed at issue, width `ADDR_BITS, no overflow for legal (h,v).
// CONFIGURATION
//  SCHED_FRAME_STATS_EN defined: extra out port frame_cycles_out[31:0] = cycles from previous SWAP to this SWAP,
//   updated in SWAP cycle, reset 0; counter saturates at 32'hFFFF_FFFF.
//  Undefined: port absent, no counter logic. Core behaviour identical either way.
// STRUCTURE
//  types.svh: sched_state_t enum {ISSUE, DRAIN, SWAP}; reuse `H_BITS/`V_BITS/`ADDR_BITS/`DISPLAY_*.
//  Sub-module rr_arbiter #(N) (req, ptr -> one-hot grant, grant index); priority issue pick inline.
// TESTING  (bench: NUM_CORES=2, WIDTH=4, HEIGHT=2, model cores with programmable delay)
//  Both cores delay 1, no pause -> 8 writes, addrs {0..7} each exactly once, one new_frame_out, then issue (0,0) next cycle.
//  Core0 delay 10, core1 delay 1 -> core1 takes most pixels; all 8 addrs written once; data matches per-pixel colour (addr^4'hA).
//  Both cores done same cycle -> grants alternate core0, core1, core0...; never two writes one cycle.
//  pause_in high after 3 issues for 20 cycles -> no starts while high; next issue is (3,0); frame completes correctly.
//  rst_in pulsed mid-frame -> outputs 0 immediately; next issue (0,0); no new_frame_out before 8 fresh writes.
//  SCHED_FRAME_STATS_EN, fixed delay 1 -> frame_cycles_out constant across consecutive frames and equals measured swap spacing.

Source files
------------

// File: rtl/march_scheduler_pkg.sv
// Shared types and display geometry for the multi-core ray-march frame scheduler.
// Optional SCHED_FRAME_STATS_EN adds a per-frame cycle counter output.
package march_scheduler_pkg;

  localparam int DISPLAY_WIDTH  = 320;
  localparam int DISPLAY_HEIGHT = 180;
  localparam int H_BITS         = 9;
  localparam int V_BITS         = 8;
  localparam int ADDR_BITS      = 16;

  typedef enum logic [1:0] {
    ISSUE,
    DRAIN,
    SWAP
  } sched_state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/march_scheduler_if.sv
// Core-issue, result-return and framebuffer-write signals of march_scheduler.
// frame_cycles_out exists only when SCHED_FRAME_STATS_EN is defined.
interface march_scheduler_if #(
  parameter int NUM_CORES = 4
);
  import march_scheduler_pkg::*;

  logic                         pause_in;
  logic [NUM_CORES-1:0]         core_start_out;
  logic [H_BITS-1:0]            hcount_out;
  logic [V_BITS-1:0]            vcount_out;
  logic [NUM_CORES-1:0]         core_done_in;
  logic [4*NUM_CORES-1:0]       core_color_in;
  logic [NUM_CORES-1:0]         core_ack_out;
  logic                         write_enable_out;
  logic [ADDR_BITS-1:0]         write_addr_out;
  logic [3:0]                   write_data_out;
  logic                         new_frame_out;
`ifdef SCHED_FRAME_STATS_EN
  logic [31:0]                  frame_cycles_out;
`endif

  modport master (
    input  pause_in,
    input  core_done_in,
    input  core_color_in,
    output core_start_out,
    output hcount_out,
    output vcount_out,
    output core_ack_out,
    output write_enable_out,
    output write_addr_out,
    output write_data_out,
    output new_frame_out
`ifdef SCHED_FRAME_STATS_EN
    , output frame_cycles_out
`endif
  );

  modport slave (
    output pause_in,
    output core_done_in,
    output core_color_in,
    input  core_start_out,
    input  hcount_out,
    input  vcount_out,
    input  core_ack_out,
    input  write_enable_out,
    input  write_addr_out,
    input  write_data_out,
    input  new_frame_out
`ifdef SCHED_FRAME_STATS_EN
    , input frame_cycles_out
`endif
  );

endinterface

// File: rtl/march_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/march_scheduler.sv
// Frame scheduler: issues raster pixels to idle marcher cores and arbitrates results onto the framebuffer.
// Define SCHED_FRAME_STATS_EN to add frame_cycles_out (swap-to-swap cycle count).
module march_scheduler
  import march_scheduler_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int WIDTH     = DISPLAY_WIDTH,
  parameter int HEIGHT    = DISPLAY_HEIGHT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  march_scheduler_if.master bus
);

  localparam int IW = idx_bits(NUM_CORES);

  sched_state_t           state;
  logic [H_BITS-1:0]      h;
  logic [V_BITS-1:0]      v;
  logic [NUM_CORES-1:0]   busy;
  logic [ADDR_BITS-1:0]   tag [NUM_CORES];
  logic [IW-1:0]          rr_ptr;

  logic [NUM_CORES-1:0]   core_start;
  logic [H_BITS-1:0]      hcount;
  logic [V_BITS-1:0]      vcount;
  logic                   new_frame;

  logic [NUM_CORES-1:0]   req;
  logic [NUM_CORES-1:0]   grant;
  logic [IW-1:0]          grant_idx;
  logic                   grant_valid;

  logic [NUM_CORES-1:0]   pick;
  logic                   can_issue;
  logic [NUM_CORES-1:0]   issue;
  logic [ADDR_BITS-1:0]   cur_addr;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [3:0]             wr_data;

  // Results from cores that hold no outstanding pixel are never granted.
  assign req = busy & bus.core_done_in;

  rr_arbiter #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Lowest clear bit of busy, as one-hot; zero when every core is busy.
  assign pick      = ~busy & (busy + NUM_CORES'(1));
  assign can_issue = (state == ISSUE) && !bus.pause_in && (pick != '0);
  assign issue     = can_issue ? pick : '0;
  assign cur_addr  = ADDR_BITS'(v) * ADDR_BITS'(WIDTH) + ADDR_BITS'(h);

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        wr_addr = tag[i];
        wr_data = bus.core_color_in[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ISSUE;
      h          <= '0;
      v          <= '0;
      busy       <= '0;
      rr_ptr     <= '0;
      core_start <= '0;
      hcount     <= '0;
      vcount     <= '0;
      new_frame  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        tag[i] <= '0;
      end
    end else begin
      core_start <= '0;
      new_frame  <= 1'b0;
      // An acked core only becomes eligible for issue on the following cycle.
      busy       <= (busy & ~grant) | issue;
      if (grant_valid) begin
        rr_ptr <= (grant_idx == IW'(NUM_CORES - 1)) ? '0 : grant_idx + IW'(1);
      end
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (issue[i]) begin
          tag[i] <= cur_addr;
        end
      end
      unique case (state)
        ISSUE: begin
          if (can_issue) begin
            core_start <= pick;
            hcount     <= h;
            vcount     <= v;
            if (h == H_BITS'(WIDTH - 1)) begin
              h <= '0;
              if (v == V_BITS'(HEIGHT - 1)) begin
                v     <= '0;
                state <= DRAIN;
              end else begin
                v <= v + V_BITS'(1);
              end
            end else begin
              h <= h + H_BITS'(1);
            end
          end
        end
        DRAIN: begin
          if (busy == '0) begin
            new_frame <= 1'b1;
            state     <= SWAP;
          end
        end
        SWAP: begin
          h     <= '0;
          v     <= '0;
          state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase
    end
  end

  assign bus.core_start_out   = core_start;
  assign bus.hcount_out       = hcount;
  assign bus.vcount_out       = vcount;
  assign bus.core_ack_out     = grant;
  assign bus.write_enable_out = grant_valid;
  assign bus.write_addr_out   = wr_addr;
  assign bus.write_data_out   = wr_data;
  assign bus.new_frame_out    = new_frame;

`ifdef SCHED_FRAME_STATS_EN
  logic [31:0] cyc_cnt;
  logic [31:0] frame_cycles;

  // cyc_cnt restarts at 1 on the swap cycle so it equals the swap spacing at the next swap.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_cnt      <= '0;
      frame_cycles <= '0;
    end else if (state == SWAP) begin
      frame_cycles <= cyc_cnt;
      cyc_cnt      <= 32'd1;
    end else if (cyc_cnt != '1) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign bus.frame_cycles_out = frame_cycles;
`endif

endmodule

// File: tb/tb_march_scheduler.sv
// Randomized bench for march_scheduler (2 cores, 4x2 frame) with delay-programmable core models.
module tb_march_scheduler;

  localparam int NC   = 2;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  march_scheduler_if #(.NUM_CORES(NC)) bus();

  march_scheduler #(
    .NUM_CORES (NC),
    .WIDTH     (W),
    .HEIGHT    (H)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // core models
  bit         done_m [NC];
  bit         pend_m [NC];
  int         cnt_m  [NC];
  logic [3:0] col_m  [NC];
  int         dly    [NC];
  bit         rand_dly = 1'b0;
  logic [NC-1:0] s_start, s_ack;
  int         s_h, s_v;

  // scheduler reference: pixel index, phase, outstanding pixel per core
  int         p, phase, rr;
  bit         owed [NC];
  int         opix [NC];
  logic [NC-1:0] exp_start;
  int         exp_pix;
  bit         exp_nf;

  // observation bookkeeping
  int cyc = 0, nf_count = 0, nf_cyc = 0, prev_nf_cyc = 0, first_start_cyc = 0;
  int written [NPIX];
  int frame_starts, frame_writes, last_frame_writes;
  int core_starts [NC];
  int last_core_starts [NC];
  int last_h, last_v, last_core, simul;
  int wr_log [$];
  bit nf_valid, stats_due;
  int stats_exp;

  task automatic drive_cores();
    for (int i = 0; i < NC; i++) begin
      bus.core_done_in[i]        = done_m[i];
      bus.core_color_in[4*i +: 4] = col_m[i];
    end
  endtask

  task automatic model_reset();
    p = 0; phase = 0; rr = 0;
    exp_start = '0; exp_pix = 0; exp_nf = 1'b0;
    frame_starts = 0; frame_writes = 0;
    nf_valid = 1'b0; stats_due = 1'b0;
    s_start = '0; s_ack = '0;
    for (int i = 0; i < NC; i++) begin
      owed[i] = 1'b0; opix[i] = 0; core_starts[i] = 0;
      done_m[i] = 1'b0; pend_m[i] = 1'b0; cnt_m[i] = 0;
    end
    for (int a = 0; a < NPIX; a++) written[a] = 0;
  endtask

  initial begin : compare
    int g, c, a, any, ic, npix;
    logic [NC-1:0] ns;
    bit nnf;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset core_start", bus.core_start_out, 0);
        chk("reset ack", bus.core_ack_out, 0);
        chk("reset write_enable", bus.write_enable_out, 0);
        chk("reset new_frame", bus.new_frame_out, 0);
        chk("reset hcount", bus.hcount_out, 0);
        model_reset();
        drive_cores();
      end else begin
        cyc++;
        g = -1;
        for (int k = 0; k < NC; k++) begin
          c = (rr + k) % NC;
          if (g < 0 && owed[c] && done_m[c]) g = c;
        end
        chk("core_start", bus.core_start_out, exp_start);
        if (exp_start != '0) begin
          chk("hcount", bus.hcount_out, exp_pix % W);
          chk("vcount", bus.vcount_out, exp_pix / W);
        end
        chk("ack", bus.core_ack_out, (g >= 0) ? (1 << g) : 0);
        chk("write_enable", bus.write_enable_out, (g >= 0) ? 1 : 0);
        if (g >= 0) begin
          chk("write_addr", bus.write_addr_out, opix[g]);
          chk("write_data", bus.write_data_out, (opix[g] ^ 10) & 15);
        end
        chk("new_frame", bus.new_frame_out, exp_nf);
`ifdef SCHED_FRAME_STATS_EN
        if (stats_due) begin
          chk("frame_cycles", bus.frame_cycles_out, stats_exp);
          stats_due = 1'b0;
        end
`endif
        if (bus.write_enable_out) begin
          a = int'(bus.write_addr_out);
          if (a < NPIX) written[a]++;
          frame_writes++;
          wr_log.push_back(a);
        end
        if (bus.core_start_out != '0) begin
          if (frame_starts == 0) first_start_cyc = cyc;
          frame_starts++;
          last_h = int'(bus.hcount_out);
          last_v = int'(bus.vcount_out);
          for (int i = 0; i < NC; i++) begin
            if (bus.core_start_out[i]) begin
              core_starts[i]++;
              last_core = i;
            end
          end
        end
        if (done_m[0] && done_m[1]) simul++;
        if (bus.new_frame_out) begin
          for (int k = 0; k < NPIX; k++) begin
            chk($sformatf("addr %0d written once", k), written[k], 1);
            written[k] = 0;
          end
          prev_nf_cyc = nf_cyc;
          nf_cyc      = cyc;
          if (nf_valid) begin
            stats_due = 1'b1;
            stats_exp = nf_cyc - prev_nf_cyc;
          end
          nf_valid          = 1'b1;
          last_frame_writes = frame_writes;
          frame_writes      = 0;
          last_core_starts  = core_starts;
          for (int i = 0; i < NC; i++) core_starts[i] = 0;
          frame_starts = 0;
          nf_count++;
        end
        s_start = bus.core_start_out;
        s_ack   = bus.core_ack_out;
        s_h     = int'(bus.hcount_out);
        s_v     = int'(bus.vcount_out);

        // advance reference by one cycle
        ns = '0; nnf = 1'b0; npix = 0; ic = 0;
        case (phase)
          0: if (!bus.pause_in) begin
            for (int i = 0; i < NC; i++) begin
              if (!owed[i] && ns == '0) begin ns[i] = 1'b1; ic = i; end
            end
            if (ns != '0) begin
              npix = p;
              p++;
              if (p == NPIX) phase = 1;
            end
          end
          1: begin
            any = 0;
            for (int i = 0; i < NC; i++) if (owed[i]) any = 1;
            if (any == 0) begin nnf = 1'b1; phase = 2; end
          end
          default: begin phase = 0; p = 0; end
        endcase
        if (g >= 0) begin owed[g] = 1'b0; rr = (g + 1) % NC; end
        if (ns != '0) begin owed[ic] = 1'b1; opix[ic] = npix; end
        exp_start = ns; exp_pix = npix; exp_nf = nnf;
      end
    end
  end

  initial begin : cores
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int i = 0; i < NC; i++) begin
          if (s_ack[i]) done_m[i] = 1'b0;
          if (s_start[i]) begin
            pend_m[i] = 1'b1;
            cnt_m[i]  = rand_dly ? int'($urandom_range(1, 12)) : dly[i];
            col_m[i]  = 4'((s_v * W + s_h) ^ 10);
          end
          if (pend_m[i]) begin
            cnt_m[i]--;
            if (cnt_m[i] <= 0) begin pend_m[i] = 1'b0; done_m[i] = 1'b1; end
          end
        end
      end
      drive_cores();
    end
  end

  task automatic wait_nf(input int budget, input string name);
    int n0, k;
    n0 = nf_count; k = 0;
    while (nf_count == n0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(name, (nf_count != n0) ? 1 : 0, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, n0;
    bus.pause_in      = 1'b0;
    bus.core_done_in  = '0;
    bus.core_color_in = '0;
    dly[0] = 1; dly[1] = 1;
    for (int i = 0; i < NC; i++) col_m[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // fixed delay 1: raster write order, known frame length and swap spacing
    wait_nf(200, "frame A completes");
    chk("frame A write count", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("frame A write order", (i < wr_log.size()) ? wr_log[i] : -1, i);
    chk("frame A first start to swap", nf_cyc - first_start_cyc, 13);
    wait_nf(200, "frame B completes");
    chk("frame B swap spacing", nf_cyc - prev_nf_cyc, 15);
`ifdef SCHED_FRAME_STATS_EN
    @(posedge clk);
    #1 chk("frame_cycles delay 1", bus.frame_cycles_out, 15);
`endif

    // slow core0: core1 should absorb most pixels
    dly[0] = 10; dly[1] = 1;
    wait_nf(400, "slow core0 frame completes");
    chk("core1 majority", (last_core_starts[1] > last_core_starts[0]) ? 1 : 0, 1);

    // simultaneous completions exercise round-robin alternation
    dly[0] = 2; dly[1] = 1; simul = 0;
    wait_nf(300, "simultaneous frame completes");
    chk("both cores done together", (simul > 0) ? 1 : 0, 1);

    // pause after the third issue
    dly[0] = 1; dly[1] = 1;
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      #1 k++;
      if (bus.core_start_out != '0 && frame_starts == 2) break;
    end
    chk("pause trigger reached", (k < 100) ? 1 : 0, 1);
    bus.pause_in = 1'b1;
    @(posedge clk);
    #1 chk("starts before pause", frame_starts, 3);
    repeat (19) @(posedge clk);
    #1 chk("no starts while paused", frame_starts, 3);
    bus.pause_in = 1'b0;
    k = 0;
    while (frame_starts < 4 && k < 50) begin @(posedge clk); #1 k++; end
    chk("resume hcount", last_h, 3);
    chk("resume vcount", last_v, 0);
    wait_nf(300, "paused frame completes");

    // random per-pixel delays with random pause
    rand_dly = 1'b1;
    for (int f = 0; f < 4; f++) begin
      n0 = nf_count; k = 0;
      while (nf_count == n0 && k < 1000) begin
        @(posedge clk);
        #1 bus.pause_in = ($urandom_range(0, 3) == 0);
        k++;
      end
      chk("random frame completes", (nf_count != n0) ? 1 : 0, 1);
    end
    bus.pause_in = 1'b0;
    rand_dly = 1'b0;

    // asynchronous reset in the middle of a frame
    dly[0] = 3; dly[1] = 5;
    k = 0;
    while (frame_starts < 3 && k < 200) begin @(posedge clk); #1 k++; end
    chk("mid-frame progress", (frame_starts >= 3) ? 1 : 0, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async reset core_start", bus.core_start_out, 0);
    chk("async reset ack", bus.core_ack_out, 0);
    chk("async reset write_enable", bus.write_enable_out, 0);
    chk("async reset write_addr", bus.write_addr_out, 0);
    chk("async reset write_data", bus.write_data_out, 0);
    chk("async reset new_frame", bus.new_frame_out, 0);
    chk("async reset vcount", bus.vcount_out, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    k = 0;
    while (frame_starts < 1 && k < 20) begin @(posedge clk); #1 k++; end
    chk("post-reset first hcount", last_h, 0);
    chk("post-reset first vcount", last_v, 0);
    chk("post-reset first core", last_core, 0);
    wait_nf(300, "post-reset frame completes");
    chk("fresh writes before swap", last_frame_writes, 8);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
